// File: rtl/l2_init_pkg.sv
//------------------------------------------------------------------------------
// l2_init_pkg
// Shared types for the L2 bank initialisation/scrub engine.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package l2_init_pkg;

  localparam int          c_DATA_WIDTH = 32;
  localparam logic [3:0]  c_BE_ALL     = 4'hF;
  localparam logic [3:0]  c_BE_NONE    = 4'h0;

  typedef enum logic [1:0] {
    MODE_FILL       = 2'd0,
    MODE_CHECK      = 2'd1,
    MODE_FILL_CHECK = 2'd2,
    MODE_RESERVED   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/l2_init_pattern_gen.sv
//------------------------------------------------------------------------------
// l2_init_pattern_gen
// Combinational data pattern: constant seed, or seed XOR zero-extended address.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module l2_init_pattern_gen
  import l2_init_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic [c_DATA_WIDTH-1:0] i_pattern,
  input  logic                    i_addr_sel,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [c_DATA_WIDTH-1:0] o_data
);

  logic [c_DATA_WIDTH-1:0] w_addr_ext;

  generate
    if (ADDR_WIDTH < c_DATA_WIDTH) begin : g_addr_pad
      assign w_addr_ext = {{(c_DATA_WIDTH-ADDR_WIDTH){1'b0}}, i_addr};
    end else begin : g_addr_trunc
      assign w_addr_ext = i_addr[c_DATA_WIDTH-1:0];
    end
  endgenerate

  assign o_data = i_addr_sel ? (i_pattern ^ w_addr_ext) : i_pattern;

endmodule

`default_nettype wire

// File: rtl/l2_mem_init_engine.sv
//------------------------------------------------------------------------------
// l2_mem_init_engine
// Sweeps one L2 bank writing a pattern and/or reading it back and counting mismatches.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module l2_mem_init_engine
  import l2_init_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [1:0]               mode_i,
  input  logic                     addr_sel_i,
  input  logic [ADDR_WIDTH-1:0]    base_i,
  input  logic [ADDR_WIDTH:0]      len_i,
  input  logic [31:0]              pattern_i,
  output logic                     mem_csn_o,
  output logic                     mem_wen_o,
  output logic [3:0]               mem_be_o,
  output logic [ADDR_WIDTH-1:0]    mem_add_o,
  output logic [31:0]              mem_wdata_o,
  input  logic [31:0]              mem_rdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  output logic [ADDR_WIDTH-1:0]    first_err_addr_o
);

  localparam logic [ADDR_WIDTH-1:0]    c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]      c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_ONE  = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                  r_state;
  mode_e                   r_mode;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH:0]     r_len;
  logic [31:0]             r_pattern;
  logic                    r_addr_sel;
  logic [ADDR_WIDTH:0]     r_cnt;
  logic [31:0]             r_exp;
  logic                    r_cmp_vld;
  logic [31:0]             r_cmp_exp;
  logic [ADDR_WIDTH-1:0]   r_cmp_addr;

  logic [31:0]             w_gen_pattern;
  logic                    w_gen_sel;
  logic [ADDR_WIDTH-1:0]   w_gen_addr;
  logic [31:0]             w_gen_data;
  logic                    w_mismatch;

  // One generator serves both the write data and the expected read value:
  // its address is the next access the FSM is about to issue.
  always_comb begin
    w_gen_pattern = r_pattern;
    w_gen_sel     = r_addr_sel;
    w_gen_addr    = mem_add_o + c_ADDR_ONE;
    if (r_state == ST_IDLE) begin
      w_gen_pattern = pattern_i;
      w_gen_sel     = addr_sel_i;
      w_gen_addr    = base_i;
    end else if ((r_state == ST_FILL) && (r_cnt == '0)) begin
      w_gen_addr    = r_base;
    end
  end

  l2_init_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pattern_gen (
    .i_pattern  (w_gen_pattern),
    .i_addr_sel (w_gen_sel),
    .i_addr     (w_gen_addr),
    .o_data     (w_gen_data)
  );

  assign w_mismatch = r_cmp_vld && (mem_rdata_i != r_cmp_exp);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state          <= ST_IDLE;
      r_mode           <= MODE_FILL;
      r_base           <= '0;
      r_len            <= '0;
      r_pattern        <= '0;
      r_addr_sel       <= 1'b0;
      r_cnt            <= '0;
      r_exp            <= '0;
      r_cmp_vld        <= 1'b0;
      r_cmp_exp        <= '0;
      r_cmp_addr       <= '0;
      mem_csn_o        <= 1'b1;
      mem_wen_o        <= 1'b1;
      mem_be_o         <= c_BE_NONE;
      mem_add_o        <= '0;
      mem_wdata_o      <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      err_cnt_o        <= '0;
      first_err_addr_o <= '0;
    end else begin
      done_o    <= 1'b0;
      r_cmp_vld <= 1'b0;
      if (abort_i) begin
        // Any read still in flight is dropped; error state is left untouched.
        r_state   <= ST_IDLE;
        mem_csn_o <= 1'b1;
        mem_wen_o <= 1'b1;
        mem_be_o  <= c_BE_NONE;
        busy_o    <= 1'b0;
      end else begin
        if (w_mismatch) begin
          err_o <= 1'b1;
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + c_ERR_ONE;
          if (!err_o) first_err_addr_o <= r_cmp_addr;
        end
        if (r_state == ST_CHECK) begin
          r_cmp_vld  <= 1'b1;
          r_cmp_exp  <= r_exp;
          r_cmp_addr <= mem_add_o;
        end

        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_mode           <= mode_e'(mode_i);
              r_base           <= base_i;
              r_len            <= len_i;
              r_pattern        <= pattern_i;
              r_addr_sel       <= addr_sel_i;
              err_o            <= 1'b0;
              err_cnt_o        <= '0;
              first_err_addr_o <= '0;
              if (len_i == '0) begin
                r_state <= ST_DONE;
                done_o  <= 1'b1;
              end else begin
                busy_o    <= 1'b1;
                mem_csn_o <= 1'b0;
                mem_be_o  <= c_BE_ALL;
                mem_add_o <= base_i;
                r_exp     <= w_gen_data;
                r_cnt     <= len_i - c_CNT_ONE;
                if (mode_e'(mode_i) == MODE_CHECK) begin
                  r_state   <= ST_CHECK;
                  mem_wen_o <= 1'b1;
                end else begin
                  r_state     <= ST_FILL;
                  mem_wen_o   <= 1'b0;
                  mem_wdata_o <= w_gen_data;
                end
              end
            end
          end

          ST_FILL: begin
            if (r_cnt != '0) begin
              mem_add_o   <= w_gen_addr;
              mem_wdata_o <= w_gen_data;
              r_cnt       <= r_cnt - c_CNT_ONE;
            end else if (r_mode == MODE_FILL) begin
              r_state   <= ST_DONE;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              mem_csn_o <= 1'b1;
              mem_wen_o <= 1'b1;
              mem_be_o  <= c_BE_NONE;
            end else begin
              r_state   <= ST_CHECK;
              mem_wen_o <= 1'b1;
              mem_add_o <= w_gen_addr;
              r_exp     <= w_gen_data;
              r_cnt     <= r_len - c_CNT_ONE;
            end
          end

          ST_CHECK: begin
            if (r_cnt != '0) begin
              mem_add_o <= w_gen_addr;
              r_exp     <= w_gen_data;
              r_cnt     <= r_cnt - c_CNT_ONE;
            end else begin
              r_state   <= ST_DRAIN;
              mem_csn_o <= 1'b1;
              mem_wen_o <= 1'b1;
              mem_be_o  <= c_BE_NONE;
            end
          end

          ST_DRAIN: begin
            r_state <= ST_DONE;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
          end

          ST_DONE: r_state <= ST_IDLE;

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
